// File: rtl/keypad_matrix_scanner_pkg.sv
// Shared types, constants and key-map helpers for the 4x3 keypad scanner.
package keypad_matrix_scanner_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD} state_t;

    localparam int NUM_ROWS  = 4;
    localparam int NUM_COLS  = 3;
    localparam int NUM_KEYS  = 12;
    localparam int KEY_STAR  = 10;
    localparam int KEY_SHARP = 11;

    // Rows 0..2 carry digits 1..9; the bottom row is '*', '0', '#'.
    function automatic logic [3:0] key_index(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] idx;
        if (r == 2'd3) begin
            case (c)
                2'd0:    idx = 4'(KEY_STAR);
                2'd1:    idx = 4'd0;
                default: idx = 4'(KEY_SHARP);
            endcase
        end else begin
            idx = 4'(r) * 4'd3 + 4'(c) + 4'd1;
        end
        return idx;
    endfunction

    function automatic logic [3:0] row_drive(input logic [1:0] r);
        return ~(4'b0001 << r);
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running row-slot counter; tick marks the last cycle of each slot.
module keypad_tick_gen #(
    parameter int SCAN_DIV = 2500
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = $clog2(SCAN_DIV);

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(SCAN_DIV - 1));

    // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Row-scanning 4x3 keypad front end: synchronise, debounce, hold one-hot key code.
module keypad_matrix_scanner
    import keypad_matrix_scanner_pkg::*;
#(
    parameter int SCAN_DIV     = 2500,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          col,
    output logic [3:0]          row,
    output logic [NUM_KEYS-1:0] key,
    output logic                key_valid,
    output logic                busy
);

    localparam int DW = $clog2(DEBOUNCE_CNT + 1);

    logic          tick;
    logic [2:0]    col_meta;
    logic [2:0]    col_sync;
    logic          single;
    logic [1:0]    col_idx;
    logic          match;
    state_t        state;
    logic [1:0]    row_idx;
    logic [1:0]    next_row_idx;
    logic [1:0]    cand_col;
    logic [DW-1:0] cnt;

    keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Idle columns read high, so the synchroniser resets to "no key".
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_meta <= 3'b111;
            col_sync <= 3'b111;
        end else begin
            col_meta <= col;
            col_sync <= col_meta;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        single  = 1'b0;
        col_idx = 2'd0;
        case (col_sync)
            3'b110:  begin single = 1'b1; col_idx = 2'd0; end
            3'b101:  begin single = 1'b1; col_idx = 2'd1; end
            3'b011:  begin single = 1'b1; col_idx = 2'd2; end
            default: ;
        endcase
    end

    assign match        = single && (col_idx == cand_col);
    assign next_row_idx = row_idx + 2'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SCAN;
            row_idx   <= 2'd0;
            row       <= 4'b1110;
            cand_col  <= 2'd0;
            cnt       <= '0;
            key       <= '0;
            key_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (single) begin
                            cand_col <= col_idx;
                            busy     <= 1'b1;
                            if (DEBOUNCE_CNT == 1) begin
                                key       <= NUM_KEYS'(1) << key_index(row_idx, col_idx);
                                key_valid <= 1'b1;
                                cnt       <= '0;
                                state     <= HOLD;
                            end else begin
                                cnt   <= DW'(1);
                                state <= DEBOUNCE;
                            end
                        end else begin
                            row_idx <= next_row_idx;
                            row     <= row_drive(next_row_idx);
                        end
                    end
                    DEBOUNCE: begin
                        if (!match) begin
                            cnt     <= '0;
                            busy    <= 1'b0;
                            state   <= SCAN;
                            row_idx <= next_row_idx;
                            row     <= row_drive(next_row_idx);
                        end else if (cnt == DW'(DEBOUNCE_CNT - 1)) begin
                            key       <= NUM_KEYS'(1) << key_index(row_idx, cand_col);
                            key_valid <= 1'b1;
                            cnt       <= '0;
                            state     <= HOLD;
                        end else begin
                            cnt <= cnt + DW'(1);
                        end
                    end
                    HOLD: begin
                        // cnt counts consecutive release samples here.
                        if (match) begin
                            cnt <= '0;
                        end else if (cnt == DW'(DEBOUNCE_CNT - 1)) begin
                            key     <= '0;
                            cnt     <= '0;
                            busy    <= 1'b0;
                            state   <= SCAN;
                            row_idx <= next_row_idx;
                            row     <= row_drive(next_row_idx);
                        end else begin
                            cnt <= cnt + DW'(1);
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench: a keypad model drives col from row; timing follows a 4-clock slot.
module tb_keypad_matrix_scanner;

    logic        clk;
    logic        rst;
    logic [2:0]  col;
    logic [3:0]  row;
    logic [11:0] key;
    logic        key_valid;
    logic        busy;

    logic        press;
    logic [1:0]  pr;
    logic [1:0]  pc;
    logic        ghost;
    logic [2:0]  col_drv;

    int errors;
    int checks;
    int strobes;
    int base;

    keypad_matrix_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .col       (col),
        .row       (row),
        .key       (key),
        .key_valid (key_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Membrane model: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        col_drv = 3'b111;
        if (press && row[pr] == 1'b0) col_drv[pc] = 1'b0;
        if (ghost && row[2] == 1'b0) col_drv = 3'b100;
    end
    assign col = col_drv;

    always @(posedge clk) begin
        if (key_valid === 1'b1) strobes++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_row"},   32'(row),       32'h0000_000e);
        check({tag, "_key"},   32'(key),       32'h0);
        check({tag, "_valid"}, 32'(key_valid), 32'h0);
        check({tag, "_busy"},  32'(busy),      32'h0);
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        strobes = 0;
        rst     = 1'b0;
        press   = 1'b0;
        ghost   = 1'b0;
        pr      = 2'd0;
        pc      = 2'd0;

        clocks(3);
        check_reset_outputs("reset");

        // Press (1,1): release reset at a negedge, the next posedge is E1.
        rst = 1'b1;
        press = 1'b1; pr = 2'd1; pc = 2'd1;
        clocks(4);
        check("p11_row_e4", 32'(row), 32'h0000_000d);
        check("p11_busy_e4", 32'(busy), 32'h0);
        clocks(4);
        check("p11_busy_e8", 32'(busy), 32'h1);
        check("p11_key_e8", 32'(key), 32'h0);
        clocks(7);
        check("p11_valid_e15", 32'(key_valid), 32'h0);
        clocks(1);
        check("p11_key_e16", 32'(key), 32'h0000_0020);
        check("p11_valid_e16", 32'(key_valid), 32'h1);
        clocks(1);
        check("p11_valid_e17", 32'(key_valid), 32'h0);
        check("p11_key_e17", 32'(key), 32'h0000_0020);
        press = 1'b0;
        clocks(10);
        check("p11_key_e27", 32'(key), 32'h0000_0020);
        check("p11_busy_e27", 32'(busy), 32'h1);
        check("p11_row_e27", 32'(row), 32'h0000_000d);
        clocks(1);
        check("p11_key_rel", 32'(key), 32'h0);
        check("p11_busy_rel", 32'(busy), 32'h0);
        check("p11_row_rel", 32'(row), 32'h0000_000b);
        check("p11_strobes", 32'(strobes), 32'h1);

        // '#' then '*'.
        base = strobes;
        press = 1'b1; pr = 2'd3; pc = 2'd2;
        clocks(16);
        check("sharp_key", 32'(key), 32'h0000_0800);
        check("sharp_valid", 32'(key_valid), 32'h1);
        press = 1'b0;
        clocks(12);
        check("sharp_key_rel", 32'(key), 32'h0);
        check("sharp_row_rel", 32'(row), 32'h0000_000e);
        press = 1'b1; pr = 2'd3; pc = 2'd0;
        clocks(24);
        check("star_key", 32'(key), 32'h0000_0400);
        check("star_valid", 32'(key_valid), 32'h1);
        press = 1'b0;
        clocks(12);
        check("star_key_rel", 32'(key), 32'h0);
        check("star_row_rel", 32'(row), 32'h0000_000e);
        check("sharp_star_strobes", 32'(strobes - base), 32'h2);

        // Bounce on row 0: detected once, then discarded.
        base = strobes;
        press = 1'b1; pr = 2'd0; pc = 2'd0;
        clocks(4);
        check("bounce_busy_det", 32'(busy), 32'h1);
        check("bounce_row_det", 32'(row), 32'h0000_000e);
        press = 1'b0;
        clocks(4);
        check("bounce_busy_drop", 32'(busy), 32'h0);
        check("bounce_row_adv", 32'(row), 32'h0000_000d);
        for (int i = 0; i < 8; i++) begin
            press = (i % 2 == 0);
            clocks(4);
            check("bounce_key", 32'(key), 32'h0);
        end
        press = 1'b0;
        check("bounce_row_end", 32'(row), 32'h0000_000d);
        check("bounce_strobes", 32'(strobes - base), 32'h0);

        // Ghost: two columns low on row 2.
        ghost = 1'b1;
        clocks(4);
        check("ghost_row_r2", 32'(row), 32'h0000_000b);
        clocks(4);
        check("ghost_row_adv", 32'(row), 32'h0000_0007);
        check("ghost_busy", 32'(busy), 32'h0);
        ghost = 1'b0;

        // '0' held with a two-tick glitch during HOLD.
        base = strobes;
        press = 1'b1; pr = 2'd3; pc = 2'd1;
        clocks(12);
        check("zero_key", 32'(key), 32'h0000_0001);
        check("zero_valid", 32'(key_valid), 32'h1);
        clocks(4);
        press = 1'b0;
        clocks(8);
        check("zero_key_glitch", 32'(key), 32'h0000_0001);
        press = 1'b1;
        clocks(12);
        check("zero_key_held", 32'(key), 32'h0000_0001);
        check("zero_busy_held", 32'(busy), 32'h1);
        check("zero_row_held", 32'(row), 32'h0000_0007);
        check("zero_strobes", 32'(strobes - base), 32'h1);

        // Reset mid-HOLD.
        rst = 1'b0;
        press = 1'b0;
        #1;
        check_reset_outputs("rst_hold");
        clocks(1);

        // Reset mid-DEBOUNCE.
        rst = 1'b1;
        press = 1'b1; pr = 2'd1; pc = 2'd1;
        clocks(8);
        check("rst_deb_busy", 32'(busy), 32'h1);
        check("rst_deb_row", 32'(row), 32'h0000_000d);
        clocks(2);
        base = strobes;
        rst = 1'b0;
        press = 1'b0;
        #1;
        check_reset_outputs("rst_deb");
        clocks(1);
        rst = 1'b1;
        clocks(3);
        check("restart_row0", 32'(row), 32'h0000_000e);
        clocks(1);
        check("restart_row1", 32'(row), 32'h0000_000d);
        check("restart_strobes", 32'(strobes - base), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
- Drives a 4x3 membrane keypad matrix and produces the 12-bit one-hot key vector consumed by the password-check, digit-count and traffic-state logic.
- This block is the source end of the key interface.
- Scans rows one at a time, synchronises and debounces the column returns, and holds the one-hot code while the key stays pressed.
- Also emits a single-cycle strobe per accepted press.

Parameters:
SCAN_DIV, 2500, clk cycles per row slot; columns are sampled once per slot on its last cycle (tick); must be >= 2
DEBOUNCE_CNT, 4, consecutive matching tick samples needed to accept a press, and consecutive non-matching samples needed to accept a release; must be >= 1

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- col  input  3  column sense, active-low (pulled up); asynchronous to clk
- row  output 4  row drive, active-low, exactly one bit low at any time
- key  output 12 one-hot key code, held while the key is pressed, otherwise 0
- key_valid  output 1  one-clk strobe when a press is accepted
- busy  output 1  high in DEBOUNCE or HOLD

Behaviour:
- Key map (row,col) to key bit:
  - (0,0)=1, (0,1)=2, (0,2)=3
  - (1,0)=4, (1,1)=5, (1,2)=6
  - (2,0)=7, (2,1)=8, (2,2)=9
  - (3,0)=10 ('*'), (3,1)=0, (3,2)=11 ('#')
- col passes through a 2-flop synchroniser before any use.
- Tick: a free-running counter 0..SCAN_DIV-1; tick is high when the count is SCAN_DIV-1. The counter restarts at 0 after every tick.
- Sample at tick: "single" means exactly one synchronised col bit is low. Zero or two-plus low bits count as no press, so ghosting and multi-key are ignored.
- Reset (asynchronous, while rst=0):
  - row=4'b1110, key=0, key_valid=0, busy=0
  - state=SCAN, tick counter=0, debounce counter=0
  - synchroniser flops=3'b111
- SCAN:
  - At tick with no single, row rotates to the next row (0->1->2->3->0).
  - At tick with a single, latch the candidate (row, col index), set debounce count=1, and go to DEBOUNCE with row frozen.
  - If DEBOUNCE_CNT=1, skip DEBOUNCE and accept immediately.
- DEBOUNCE (row frozen):
  - At tick with the same single column, increment the count.
  - When the count reaches DEBOUNCE_CNT, accept: on the next clk edge key=one-hot(candidate), key_valid=1 for exactly one cycle, state=HOLD, count=0.
  - At tick with a mismatch (different column, none, or multi), discard the candidate and go to SCAN. The row advances to the next row on that same edge.
- HOLD (row frozen, key stable):
  - At tick with the candidate still single-low, clear the release count.
  - At tick otherwise, increment the release count.
  - When the release count reaches DEBOUNCE_CNT, key=0 on the next edge and state=SCAN with the row advanced.
  - No key_valid is issued on release. A new press in HOLD is never reported until release completes.
- Timing:
  - key_valid and key rise on the same edge.
  - key never changes while key_valid=1.
- Latency: a press stable from the first sampling tick of its row is accepted DEBOUNCE_CNT-1 slots after that tick, plus 1 clk.
- Worst-case detection start is 4 slots (one full rotation).
- Reset asserted mid-DEBOUNCE or mid-HOLD: outputs drop immediately to their reset values and no strobe is issued.

Decomposition:
- Shared package holds:
  - the state enum {SCAN, DEBOUNCE, HOLD}
  - KEY_STAR=10, KEY_SHARP=11, NUM_ROWS=4, NUM_COLS=3
  - the (row,col)->key-index lookup function
- One natural sub-module: keypad_tick_gen. It is the SCAN_DIV counter producing tick and uses the same asynchronous active-low rst.
- Synchroniser and FSM stay in the top module.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3):
- Press (1,1) cleanly:
  - row holds 4'b1101
  - key=12'h020 and key_valid is one pulse, 2 slots after the first detecting tick +1 clk
  - busy=1 until release
  - release: key=0 after 3 non-matching ticks and row resumes rotation to 4'b1011
- Press '#' (3,2) then '*' (3,0) in sequence: key=12'h800 with one strobe, then 0, then 12'h400 with one strobe; exactly 2 strobes total.
- Bounce: col toggles between 3'b110 and 3'b111 on alternate ticks in row 0 -> key_valid never asserts, key stays 0, scanning continues.
- Ghost: col=3'b100 (two low) on row 2 -> no DEBOUNCE entry, busy=0, row advances to 4'b0111.
- Press '0' (3,1) held; during HOLD col glitches high for 2 ticks then returns low -> no release, key stays 12'h001, no second strobe.
- rst pulled low mid-DEBOUNCE and mid-HOLD -> row=4'b1110, key=0, key_valid=0, busy=0 immediately; after rst rises, scanning restarts from row 0.
